risk_regfile_seq: RTL and testbench

//  Parametrised tensor register file with a command sequencer for the risk unit. Accepts one

---
 rtl/risk_pkg.sv | 38 +++
 rtl/risk_regfile_seq_if.sv | 52 +++++
 rtl/risk_lane_alu.sv | 29 ++
 rtl/risk_regfile_seq.sv | 130 +++++++++++++
 tb/tb_risk_regfile_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/risk_pkg.sv
// Shared types and helpers for the risk tensor register file.
// RISK_RELU_EN enables func 101 (RELU); without it that code is rejected.
package risk_pkg;

  typedef enum logic [2:0] {
    F_LOAD  = 3'b000,
    F_STORE = 3'b001,
    F_ZERO  = 3'b010,
    F_ADD   = 3'b011,
    F_MUL   = 3'b100,
    F_RELU  = 3'b101
  } func_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MREQ, S_MWAIT} state_e;

`ifdef RISK_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  function automatic int aw_w(input int logcnt);
    return 10 + logcnt;
  endfunction

  function automatic int sw_w(input int logcnt);
    return 9 + logcnt;
  endfunction

  function automatic int ridx_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  function automatic logic func_illegal(input logic [2:0] f);
    return (f > 3'd5) || ((f == F_RELU) && !RELU_EN);
  endfunction

endpackage

// File: rtl/risk_regfile_seq_if.sv
// Command (core side) and memory (dcache side) handshake bundles.
// The command master is the decoder; the memory master is the sequencer.
interface risk_cmd_if #(
  parameter int NREGS  = 4,
  parameter int LOGCNT = 5
);
  localparam int AW   = risk_pkg::aw_w(LOGCNT);
  localparam int SW   = risk_pkg::sw_w(LOGCNT);
  localparam int RIDX = risk_pkg::ridx_w(NREGS);

  logic            valid;
  logic            ready;
  logic [2:0]      func;
  logic [RIDX-1:0] rd;
  logic [RIDX-1:0] rs1;
  logic [RIDX-1:0] rs2;
  logic [AW-1:0]   addr;
  logic [SW-1:0]   stride_x;
  logic [SW-1:0]   stride_y;
  logic            done;
  logic            err;

  modport master (output valid, func, rd, rs1, rs2, addr, stride_x, stride_y,
                  input  ready, done, err);
  modport slave  (input  valid, func, rd, rs1, rs2, addr, stride_x, stride_y,
                  output ready, done, err);
endinterface

interface risk_mem_if #(
  parameter int SZ     = 4,
  parameter int LOGCNT = 5,
  parameter int BITS   = 18
);
  localparam int AW    = risk_pkg::aw_w(LOGCNT);
  localparam int SW    = risk_pkg::sw_w(LOGCNT);
  localparam int LANES = SZ * SZ;

  logic                        req;
  logic                        we;
  logic [AW-1:0]               addr;
  logic [SW-1:0]               stride_x;
  logic [SW-1:0]               stride_y;
  logic [LANES-1:0][BITS-1:0]  wdata;
  logic                        gnt;
  logic                        rvalid;
  logic [LANES-1:0][BITS-1:0]  rdata;

  modport master (output req, we, addr, stride_x, stride_y, wdata,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, stride_x, stride_y, wdata,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/risk_lane_alu.sv
// Combinational per-lane tile ALU: ZERO/ADD/MUL, plus RELU when RISK_RELU_EN.
// Arithmetic is unsigned and wraps to BITS.
module risk_lane_alu import risk_pkg::*; #(
  parameter int LANES = 16,
  parameter int BITS  = 18
) (
  input  logic [2:0]                func,
  input  logic [LANES-1:0][BITS-1:0] a,
  input  logic [LANES-1:0][BITS-1:0] b,
  output logic [LANES-1:0][BITS-1:0] y
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BITS-1:0] r;
    always_comb begin
      r = '0;
      case (func)
        F_ADD:   r = a[i] + b[i];
        F_MUL:   r = a[i] * b[i];
`ifdef RISK_RELU_EN
        F_RELU:  r = a[i][BITS-1] ? '0 : a[i];
`endif
        default: r = '0;
      endcase
    end
    assign y[i] = r;
  end

endmodule

// File: rtl/risk_regfile_seq.sv
// Tensor register file + single-command sequencer (LOAD/STORE via dcache, ZERO/ADD/MUL in place).
// RISK_RELU_EN adds RELU (func 101) on the EXEC path.
module risk_regfile_seq import risk_pkg::*; #(
  parameter int SZ       = 4,
  parameter int LOGCNT   = 5,
  parameter int BITS     = 18,
  parameter int NREGS    = 4,
  parameter int VIEW_REG = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  risk_cmd_if.slave                     cmd,
  risk_mem_if.master                    mem,
  output logic [SZ*SZ-1:0][BITS-1:0]    reg_view
);

  localparam int AW    = aw_w(LOGCNT);
  localparam int SW    = sw_w(LOGCNT);
  localparam int RIDX  = ridx_w(NREGS);
  localparam int LANES = SZ * SZ;

  typedef logic [LANES-1:0][BITS-1:0] tile_t;

  state_e            state;
  tile_t [NREGS-1:0] regs;
  logic [2:0]        func_q;
  logic [RIDX-1:0]   rd_q, rs1_q, rs2_q;
  logic [AW-1:0]     addr_q;
  logic [SW-1:0]     sx_q, sy_q;
  logic              req_q, we_q, done_q, err_q;
  tile_t             wdata_q;
  tile_t             alu_y;
  logic              accept, idx_bad;

  assign cmd.ready = (state == S_IDLE) && resetn;
  assign accept    = cmd.valid && cmd.ready;
  assign idx_bad   = (int'(cmd.rd) >= NREGS) || (int'(cmd.rs1) >= NREGS) ||
                     (int'(cmd.rs2) >= NREGS);

  risk_lane_alu #(.LANES(LANES), .BITS(BITS)) u_alu (
    .func (func_q),
    .a    (regs[rs1_q]),
    .b    (regs[rs2_q]),
    .y    (alu_y)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      regs    <= '0;
      func_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      addr_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (func_illegal(cmd.func) || idx_bad) begin
            err_q <= 1'b1;
          end else begin
            func_q <= cmd.func;
            rd_q   <= cmd.rd;
            rs1_q  <= cmd.rs1;
            rs2_q  <= cmd.rs2;
            addr_q <= cmd.addr;
            sx_q   <= cmd.stride_x;
            sy_q   <= cmd.stride_y;
            case (cmd.func)
              F_LOAD: begin
                state <= S_MREQ;
                req_q <= 1'b1;
                we_q  <= 1'b0;
              end
              F_STORE: begin
                // snapshot now so later register writes cannot disturb the store
                state   <= S_MREQ;
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                wdata_q <= regs[cmd.rs1];
              end
              default: state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          regs[rd_q] <= alu_y;
          done_q     <= 1'b1;
          state      <= S_IDLE;
        end
        S_MREQ: if (mem.gnt) begin
          req_q <= 1'b0;
          we_q  <= 1'b0;
          if (we_q) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            state <= S_MWAIT;
          end
        end
        S_MWAIT: if (mem.rvalid) begin
          regs[rd_q] <= mem.rdata;
          done_q     <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd.done     = done_q;
  assign cmd.err      = err_q;
  assign mem.req      = req_q;
  assign mem.we       = we_q;
  assign mem.addr     = addr_q;
  assign mem.stride_x = sx_q;
  assign mem.stride_y = sy_q;
  assign mem.wdata    = wdata_q;
  assign reg_view     = regs[VIEW_REG];

endmodule

// File: tb/tb_risk_regfile_seq.sv
// Directed bench for risk_regfile_seq; the RELU case follows RISK_RELU_EN.
module tb_risk_regfile_seq;
  import risk_pkg::*;

  localparam int SZ = 4, LOGCNT = 5, BITS = 18, NREGS = 4, VIEW_REG = 0;
  localparam int LANES = SZ * SZ, AW = 15, SW = 14, RIDX = 2;
  typedef logic [LANES-1:0][BITS-1:0] tile_t;

  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  tile_t reg_view;
  int    n_tests = 0;
  int    n_fail = 0;
  tile_t t1, tt, e;

  risk_cmd_if #(.NREGS(NREGS), .LOGCNT(LOGCNT)) cmd_bus ();
  risk_mem_if #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS)) mem_bus ();

  risk_regfile_seq #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS), .NREGS(NREGS),
                     .VIEW_REG(VIEW_REG)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cmd      (cmd_bus),
    .mem      (mem_bus),
    .reg_view (reg_view)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] f, input int rd, input int rs1, input int rs2,
                           input int a, input int sx, input int sy);
    cmd_bus.func     = f;
    cmd_bus.rd       = RIDX'(rd);
    cmd_bus.rs1      = RIDX'(rs1);
    cmd_bus.rs2      = RIDX'(rs2);
    cmd_bus.addr     = AW'(a);
    cmd_bus.stride_x = SW'(sx);
    cmd_bus.stride_y = SW'(sy);
  endtask

  // returns 1 ns after the accepting edge
  task automatic issue(input logic [2:0] f, input int rd, input int rs1, input int rs2,
                       input int a, input int sx, input int sy);
    drive_cmd(f, rd, rs1, rs2, a, sx, sy);
    cmd_bus.valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_bus.ready; i++) tick();
    if (!cmd_bus.ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: ready stayed %b, want 1", cmd_bus.ready);
    end
    tick();
    cmd_bus.valid = 1'b0;
  endtask

  task automatic run(input int n, output int nd, output int ne);
    nd = 0; ne = 0;
    repeat (n) begin
      tick();
      nd += int'(cmd_bus.done);
      ne += int'(cmd_bus.err);
    end
  endtask

  task automatic quick_load(input int rd, input tile_t t);
    issue(F_LOAD, rd, 0, 0, 0, 1, 1);
    mem_bus.gnt = 1'b1;
    tick();
    mem_bus.gnt = 1'b0;
    mem_bus.rdata = t;
    mem_bus.rvalid = 1'b1;
    tick();
    mem_bus.rvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    cmd_bus.valid = 1'b0;
    drive_cmd(3'b000, 0, 0, 0, 0, 0, 0);
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    resetn = 1'b0;
    repeat (2) tick();
    n_tests++; if (cmd_bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_bus.ready); end
    n_tests++; if (mem_bus.req !== 1'b0 || mem_bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_mem: req=%b we=%b want 0 0", mem_bus.req, mem_bus.we); end
    n_tests++; if (cmd_bus.done !== 1'b0 || cmd_bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done=%b err=%b want 0 0", cmd_bus.done, cmd_bus.err); end
    n_tests++; if (reg_view !== '0) begin n_fail++; $display("FAIL reset_view: got %h want 0", reg_view); end
    resetn = 1'b1;
    tick();
    n_tests++; if (cmd_bus.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", cmd_bus.ready); end
  endtask

  task automatic test_zero_add();
    int nd, ne;
    issue(F_ZERO, 0, 0, 0, 0, 0, 0);
    n_tests++; if (cmd_bus.done !== 1'b0 || cmd_bus.ready !== 1'b0) begin n_fail++; $display("FAIL zero_exec: done=%b ready=%b want 0 0", cmd_bus.done, cmd_bus.ready); end
    tick();
    n_tests++; if (cmd_bus.done !== 1'b1 || cmd_bus.ready !== 1'b1) begin n_fail++; $display("FAIL zero_done: done=%b ready=%b want 1 1", cmd_bus.done, cmd_bus.ready); end
    tick();
    n_tests++; if (cmd_bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: done=%b want 0", cmd_bus.done); end
    issue(F_ADD, 0, 0, 0, 0, 0, 0);
    run(3, nd, ne);
    n_tests++; if (nd != 1 || ne != 0) begin n_fail++; $display("FAIL add0_pulses: done=%0d err=%0d want 1 0", nd, ne); end
    n_tests++; if (reg_view !== '0) begin n_fail++; $display("FAIL add0_view: got %h want 0", reg_view); end
  endtask

  task automatic test_load();
    int nreq, nd;
    for (int k = 0; k < LANES; k++) t1[k] = BITS'(k + 1);
    issue(F_LOAD, 1, 0, 0, 'h10, 1, 4);
    n_tests++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b0) begin n_fail++; $display("FAIL load_req: req=%b we=%b want 1 0", mem_bus.req, mem_bus.we); end
    n_tests++; if (mem_bus.addr !== 15'h010 || mem_bus.stride_x !== 14'd1 || mem_bus.stride_y !== 14'd4) begin
      n_fail++; $display("FAIL load_addr: addr=%h sx=%0d sy=%0d want 010 1 4", mem_bus.addr, mem_bus.stride_x, mem_bus.stride_y); end
    nreq = int'(mem_bus.req); nd = 0;
    // stray rvalid while still requesting must be ignored
    mem_bus.rdata = '1; mem_bus.rvalid = 1'b1;
    tick(); mem_bus.rvalid = 1'b0;
    nreq += int'(mem_bus.req); nd += int'(cmd_bus.done);
    tick();
    nreq += int'(mem_bus.req); nd += int'(cmd_bus.done);
    mem_bus.gnt = 1'b1;
    tick(); mem_bus.gnt = 1'b0;
    nreq += int'(mem_bus.req); nd += int'(cmd_bus.done);
    tick(); nd += int'(cmd_bus.done);
    mem_bus.rdata = t1; mem_bus.rvalid = 1'b1;
    tick(); mem_bus.rvalid = 1'b0; nd += int'(cmd_bus.done);
    tick(); nd += int'(cmd_bus.done);
    n_tests++; if (nreq != 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d want 3", nreq); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL load_done: got %0d want 1", nd); end
    n_tests++; if (reg_view !== '0) begin n_fail++; $display("FAIL load_rd_route: view=%h want 0", reg_view); end
  endtask

  task automatic test_alu();
    int nd, ne;
    tt[0] = 18'h3FFFF; tt[1] = 18'h20000; tt[2] = 18'h00003; tt[3] = 18'h1FFFF;
    for (int k = 4; k < LANES; k++) tt[k] = BITS'(k);
    quick_load(2, tt);
    issue(F_ADD, 0, 2, 2, 0, 0, 0);
    run(2, nd, ne);
    e[0] = 18'h3FFFE; e[1] = 18'h00000; e[2] = 18'h00006; e[3] = 18'h3FFFE;
    for (int k = 4; k < LANES; k++) e[k] = BITS'(2 * k);
    n_tests++; if (reg_view !== e || nd != 1) begin n_fail++; $display("FAIL add_wrap: got %h want %h done=%0d", reg_view, e, nd); end
    issue(F_MUL, 0, 2, 2, 0, 0, 0);
    run(2, nd, ne);
    e[0] = 18'h00001; e[1] = 18'h00000; e[2] = 18'h00009; e[3] = 18'h00001;
    for (int k = 4; k < LANES; k++) e[k] = BITS'(k * k);
    n_tests++; if (reg_view !== e || nd != 1) begin n_fail++; $display("FAIL mul_wrap: got %h want %h done=%0d", reg_view, e, nd); end
    issue(F_MUL, 0, 0, 0, 0, 0, 0);
    run(2, nd, ne);
    e[2] = 18'd81;
    for (int k = 4; k < LANES; k++) e[k] = BITS'(k * k * k * k);
    n_tests++; if (reg_view !== e) begin n_fail++; $display("FAIL mul_self: got %h want %h", reg_view, e); end
    issue(F_ADD, 0, 1, 1, 0, 0, 0);
    run(2, nd, ne);
    for (int k = 0; k < LANES; k++) e[k] = BITS'(2 * (k + 1));
    n_tests++; if (reg_view !== e) begin n_fail++; $display("FAIL add_r1: got %h want %h", reg_view, e); end
  endtask

  task automatic test_back_to_back();
    drive_cmd(F_STORE, 0, 1, 0, 'h123, 2, 8);
    cmd_bus.valid = 1'b1;
    tick();
    drive_cmd(F_ZERO, 0, 0, 0, 'h55, 0, 0);
    n_tests++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1 || mem_bus.wdata !== t1) begin
      n_fail++; $display("FAIL store_req: req=%b we=%b wdata=%h want 1 1 %h", mem_bus.req, mem_bus.we, mem_bus.wdata, t1); end
    tick();
    n_tests++; if (cmd_bus.ready !== 1'b0 || mem_bus.addr !== 15'h123 || mem_bus.stride_y !== 14'd8) begin
      n_fail++; $display("FAIL store_hold: ready=%b addr=%h sy=%0d want 0 123 8", cmd_bus.ready, mem_bus.addr, mem_bus.stride_y); end
    mem_bus.gnt = 1'b1;
    tick(); mem_bus.gnt = 1'b0;
    n_tests++; if (cmd_bus.done !== 1'b1 || mem_bus.req !== 1'b0 || cmd_bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL store_done: done=%b req=%b ready=%b want 1 0 1", cmd_bus.done, mem_bus.req, cmd_bus.ready); end
    tick(); cmd_bus.valid = 1'b0;
    n_tests++; if (cmd_bus.ready !== 1'b0 || cmd_bus.done !== 1'b0) begin
      n_fail++; $display("FAIL second_accept: ready=%b done=%b want 0 0", cmd_bus.ready, cmd_bus.done); end
    tick();
    n_tests++; if (cmd_bus.done !== 1'b1 || reg_view !== '0) begin
      n_fail++; $display("FAIL second_done: done=%b view=%h want 1 0", cmd_bus.done, reg_view); end
  endtask

  task automatic test_illegal();
    int nd, ne;
    issue(F_ADD, 0, 1, 1, 0, 0, 0);
    run(2, nd, ne);
    for (int k = 0; k < LANES; k++) e[k] = BITS'(2 * (k + 1));
    issue(3'b111, 0, 1, 1, 0, 0, 0);
    n_tests++; if (cmd_bus.err !== 1'b1 || cmd_bus.done !== 1'b0 || cmd_bus.ready !== 1'b1 || mem_bus.req !== 1'b0) begin
      n_fail++; $display("FAIL ill111: err=%b done=%b ready=%b req=%b want 1 0 1 0", cmd_bus.err, cmd_bus.done, cmd_bus.ready, mem_bus.req); end
    tick();
    n_tests++; if (cmd_bus.err !== 1'b0 || reg_view !== e) begin
      n_fail++; $display("FAIL ill111_after: err=%b view=%h want 0 %h", cmd_bus.err, reg_view, e); end
    issue(3'b110, 0, 1, 1, 0, 0, 0);
    run(3, nd, ne);
    n_tests++; if (ne != 0 || nd != 0 || reg_view !== e) begin
      n_fail++; $display("FAIL ill110: err=%0d done=%0d view=%h want 0 0 %h (err pulse sampled before run)", ne, nd, reg_view, e); end
`ifdef RISK_RELU_EN
    tt[0] = 18'h20000; tt[1] = 18'h1FFFF; tt[2] = 18'h3FFFF;
    for (int k = 3; k < LANES; k++) tt[k] = BITS'(k);
    quick_load(2, tt);
    issue(F_RELU, 0, 2, 0, 0, 0, 0);
    run(2, nd, ne);
    e = tt; e[0] = '0; e[2] = '0;
    n_tests++; if (reg_view !== e || nd != 1 || ne != 0) begin
      n_fail++; $display("FAIL relu: view=%h done=%0d err=%0d want %h 1 0", reg_view, nd, ne, e); end
`else
    issue(F_RELU, 0, 1, 1, 0, 0, 0);
    n_tests++; if (cmd_bus.err !== 1'b1 || cmd_bus.done !== 1'b0) begin
      n_fail++; $display("FAIL relu_off: err=%b done=%b want 1 0", cmd_bus.err, cmd_bus.done); end
    run(2, nd, ne);
    n_tests++; if (reg_view !== e || nd != 0) begin
      n_fail++; $display("FAIL relu_off_regs: view=%h done=%0d want %h 0", reg_view, nd, e); end
`endif
  endtask

  task automatic test_reset_mid();
    int nd, ne;
    issue(F_LOAD, 1, 0, 0, 'h40, 1, 1);
    mem_bus.gnt = 1'b1;
    tick(); mem_bus.gnt = 1'b0;
    resetn = 1'b0;
    #1;
    n_tests++; if (reg_view !== '0 || mem_bus.req !== 1'b0 || cmd_bus.ready !== 1'b0) begin
      n_fail++; $display("FAIL mwait_reset: view=%h req=%b ready=%b want 0 0 0", reg_view, mem_bus.req, cmd_bus.ready); end
    mem_bus.rdata = '1; mem_bus.rvalid = 1'b1;
    tick();
    resetn = 1'b1; mem_bus.rvalid = 1'b0;
    run(2, nd, ne);
    n_tests++; if (nd != 0 || ne != 0) begin n_fail++; $display("FAIL abort_pulses: done=%0d err=%0d want 0 0", nd, ne); end
    issue(F_ADD, 0, 1, 2, 0, 0, 0);
    run(2, nd, ne);
    n_tests++; if (reg_view !== '0 || nd != 1) begin n_fail++; $display("FAIL regs_cleared: view=%h done=%0d want 0 1", reg_view, nd); end
    issue(F_LOAD, 0, 0, 0, 'h80, 1, 1);
    n_tests++; if (mem_bus.req !== 1'b1) begin n_fail++; $display("FAIL mreq_before: req=%b want 1", mem_bus.req); end
    resetn = 1'b0;
    #1;
    n_tests++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("FAIL mreq_reset: req=%b want 0", mem_bus.req); end
    tick();
    resetn = 1'b1;
    tick();
    for (int k = 0; k < LANES; k++) e[k] = BITS'(k + 100);
    quick_load(0, e);
    n_tests++; if (reg_view !== e) begin n_fail++; $display("FAIL post_reset_load: view=%h want %h", reg_view, e); end
  endtask

  initial begin
    test_reset();
    test_zero_add();
    test_load();
    test_alu();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
